// File: rtl/redmule_pkg.sv
// Shared RedMulE types: HCI size descriptor, TCDM response opcodes and the
// response FIFO entry used by the TCDM target.
package redmule_pkg;

  typedef struct packed {
    int unsigned DW;
    int unsigned AW;
    int unsigned BW;
    int unsigned UW;
    int unsigned IW;
  } hci_size_parameter_t;

  localparam hci_size_parameter_t HCI_SIZE_TCDM_DEFAULT =
    '{DW: 32'd128, AW: 32'd32, BW: 32'd8, UW: 32'd2, IW: 32'd8};

  localparam logic RESP_OPC_OK  = 1'b0;
  localparam logic RESP_OPC_ERR = 1'b1;

  localparam int unsigned TCDM_DW = HCI_SIZE_TCDM_DEFAULT.DW;
  localparam int unsigned TCDM_UW = HCI_SIZE_TCDM_DEFAULT.UW;
  localparam int unsigned TCDM_IW = HCI_SIZE_TCDM_DEFAULT.IW;

  typedef struct packed {
    logic [TCDM_DW-1:0] data;
    logic               opc;
    logic [TCDM_IW-1:0] id;
    logic [TCDM_UW-1:0] user;
  } tcdm_resp_entry_t;

  // Pointer width that stays legal for a single-entry structure.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 32'd1) ? $clog2(v) : 32'd1;
  endfunction

endpackage

// File: rtl/hci_outstanding_intf.sv
// HCI outstanding TCDM channel: decoupled request and in-order response.
interface hci_outstanding_intf #(
  parameter int unsigned DW = 128,
  parameter int unsigned AW = 32,
  parameter int unsigned BW = 8,
  parameter int unsigned UW = 2,
  parameter int unsigned IW = 8
) ();

  logic             req_valid;
  logic             req_ready;
  logic [AW-1:0]    req_add;
  logic             req_wen;
  logic [DW-1:0]    req_data;
  logic [DW/BW-1:0] req_be;
  logic [UW-1:0]    req_user;
  logic [IW-1:0]    req_id;

  logic             resp_valid;
  logic             resp_ready;
  logic [DW-1:0]    resp_data;
  logic             resp_opc;
  logic [UW-1:0]    resp_user;
  logic [IW-1:0]    resp_id;

  modport initiator (
    output req_valid, req_add, req_wen, req_data, req_be, req_user, req_id, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_opc, resp_user, resp_id
  );

  modport target (
    input  req_valid, req_add, req_wen, req_data, req_be, req_user, req_id, resp_ready,
    output req_ready, resp_valid, resp_data, resp_opc, resp_user, resp_id
  );

endinterface

// File: rtl/redmule_tcdm_resp_fifo.sv
// Synchronous response FIFO; pointers wrap modulo DEPTH so any depth works.
module redmule_tcdm_resp_fifo
  import redmule_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = tcdm_resp_entry_t,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  entry_t           wdata,
  input  logic             pop,
  output entry_t           rdata,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] occ
);

  localparam int unsigned PTR_W = clog2_min1(DEPTH);

  entry_t           mem_r [DEPTH];
  logic [PTR_W-1:0] wptr_r;
  logic [PTR_W-1:0] rptr_r;
  logic [CNT_W-1:0] cnt_r;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
  endfunction

  // Read/write pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r <= PTR_W'(0);
      rptr_r <= PTR_W'(0);
      cnt_r  <= CNT_W'(0);
    end else if (clear) begin
      wptr_r <= PTR_W'(0);
      rptr_r <= PTR_W'(0);
      cnt_r  <= CNT_W'(0);
    end else begin
      if (push) wptr_r <= ptr_inc(wptr_r);
      if (pop)  rptr_r <= ptr_inc(rptr_r);
      case ({push, pop})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Entry storage, zeroed on reset so an idle head reads as all-zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_r[i] <= entry_t'(0);
    end else if (push && !clear) begin
      mem_r[wptr_r] <= wdata;
    end
  end

  assign rdata = mem_r[rptr_r];
  assign empty = (cnt_r == CNT_W'(0));
  assign full  = (cnt_r == CNT_W'(DEPTH));
  assign occ   = cnt_r;

endmodule

// File: rtl/redmule_tcdm_target.sv
// HCI outstanding TCDM responder in front of a 1-cycle-latency word SRAM;
// returns one in-order response per accepted request.
module redmule_tcdm_target
  import redmule_pkg::*;
#(
  parameter hci_size_parameter_t HCI_SIZE_tcdm = HCI_SIZE_TCDM_DEFAULT,
  parameter int unsigned RESP_DEPTH = 4,
  parameter int unsigned MEM_AW = 12
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        clear_i,
  input  logic                                        stall_i,
  hci_outstanding_intf.target                         tcdm,
  output logic                                        mem_req_o,
  output logic                                        mem_we_o,
  output logic [MEM_AW-1:0]                           mem_addr_o,
  output logic [HCI_SIZE_tcdm.DW-1:0]                 mem_wdata_o,
  output logic [HCI_SIZE_tcdm.DW/HCI_SIZE_tcdm.BW-1:0] mem_be_o,
  input  logic [HCI_SIZE_tcdm.DW-1:0]                 mem_rdata_i,
  output logic                                        busy_o
);

  localparam int unsigned DW    = HCI_SIZE_tcdm.DW;
  localparam int unsigned AW    = HCI_SIZE_tcdm.AW;
  localparam int unsigned UW    = HCI_SIZE_tcdm.UW;
  localparam int unsigned IW    = HCI_SIZE_tcdm.IW;
  localparam int unsigned BOFF  = $clog2(DW / 8);
  localparam int unsigned IDX_W = AW - BOFF;
  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int unsigned USE_W = CNT_W + 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          opc;
    logic [IW-1:0] id;
    logic [UW-1:0] user;
  } resp_entry_t;

  logic [IDX_W-1:0] idx_s;
  logic [BOFF-1:0]  unused_byte_off_s;
  logic             range_err_s;
  logic [USE_W-1:0] credits_used_s;
  logic             req_ready_s;
  logic             accept_s;
  logic             pop_s;
  logic             push_s;
  logic             iss_valid_r;
  logic             iss_read_r;
  logic             iss_err_r;
  logic [IW-1:0]    iss_id_r;
  logic [UW-1:0]    iss_user_r;
  resp_entry_t      push_entry_s;
  resp_entry_t      head_s;
  logic             fifo_empty_s;
  logic             unused_fifo_full_s;
  logic [CNT_W-1:0] occ_s;

  assign idx_s             = tcdm.req_add[AW-1:BOFF];
  assign unused_byte_off_s = tcdm.req_add[BOFF-1:0];

  generate
    if (IDX_W > MEM_AW) begin : g_range_check
      assign range_err_s = |idx_s[IDX_W-1:MEM_AW];
    end else begin : g_no_range_check
      assign range_err_s = 1'b0;
    end
  endgenerate

  // A pop in this cycle frees its slot for a same-cycle accept, so the
  // issue register plus FIFO can never exceed RESP_DEPTH entries.
  assign pop_s          = !fifo_empty_s && tcdm.resp_ready;
  assign credits_used_s = USE_W'(occ_s) + USE_W'(iss_valid_r) - USE_W'(pop_s);
  assign req_ready_s    = !stall_i && !clear_i && (credits_used_s < USE_W'(RESP_DEPTH));
  assign accept_s       = tcdm.req_valid && req_ready_s;
  assign tcdm.req_ready = req_ready_s;

  assign mem_req_o   = accept_s && !range_err_s;
  assign mem_we_o    = !tcdm.req_wen;
  assign mem_addr_o  = idx_s[MEM_AW-1:0];
  assign mem_wdata_o = tcdm.req_data;
  assign mem_be_o    = tcdm.req_be;

  // Issue register: tracks the request whose SRAM data lands next cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      iss_valid_r <= 1'b0;
      iss_read_r  <= 1'b0;
      iss_err_r   <= 1'b0;
      iss_id_r    <= IW'(0);
      iss_user_r  <= UW'(0);
    end else if (clear_i) begin
      iss_valid_r <= 1'b0;
      iss_read_r  <= 1'b0;
      iss_err_r   <= 1'b0;
      iss_id_r    <= IW'(0);
      iss_user_r  <= UW'(0);
    end else begin
      iss_valid_r <= accept_s;
      if (accept_s) begin
        iss_read_r <= tcdm.req_wen;
        iss_err_r  <= range_err_s;
        iss_id_r   <= tcdm.req_id;
        iss_user_r <= tcdm.req_user;
      end
    end
  end

  // Response entry built from the issue register and the SRAM read port
  always_comb begin
    push_entry_s.data = {DW{1'b0}};
    if (iss_read_r && !iss_err_r) begin
      push_entry_s.data = mem_rdata_i;
    end else begin
      push_entry_s.data = {DW{1'b0}};
    end
    push_entry_s.opc  = iss_err_r ? RESP_OPC_ERR : RESP_OPC_OK;
    push_entry_s.id   = iss_id_r;
    push_entry_s.user = iss_user_r;
  end

  assign push_s = iss_valid_r && !clear_i;

  redmule_tcdm_resp_fifo #(
    .DEPTH   (RESP_DEPTH),
    .entry_t (resp_entry_t)
  ) i_resp_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .clear (clear_i),
    .push  (push_s),
    .wdata (push_entry_s),
    .pop   (pop_s),
    .rdata (head_s),
    .empty (fifo_empty_s),
    .full  (unused_fifo_full_s),
    .occ   (occ_s)
  );

  assign tcdm.resp_valid = !fifo_empty_s;
  assign tcdm.resp_data  = head_s.data;
  assign tcdm.resp_opc   = head_s.opc;
  assign tcdm.resp_id    = head_s.id;
  assign tcdm.resp_user  = head_s.user;

  assign busy_o = iss_valid_r || !fifo_empty_s;

endmodule

// File: doc/redmule_tcdm_target.md
# redmule_tcdm_target

Responder end of the HCI outstanding TCDM protocol. It accepts requests from an `hci_outstanding_intf` initiator, such as the RedMulE streamer's load/store mux, and services them against a single-port, 1-cycle-latency word SRAM. It returns exactly one in-order response per request, carrying the request's ID and user fields. It serves as the cluster-side memory responder in standalone RedMulE integration and as the TCDM model in the streamer testbench. The `stall_i` input injects backpressure.

## Interface
Parameters:
- `HCI_SIZE_PARAM(tcdm)`, default `'{DW:128, AW:32, BW:8, UW:2, IW:8}`: HCI sizes. DW must be a power of two ≥32.
- `RESP_DEPTH`, default 4: response FIFO depth, which is also the maximum number of outstanding requests. Must be ≥2.
- `MEM_AW`, default 12: SRAM word-address width.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `clear_i`, in, 1: synchronous flush.
- `stall_i`, in, 1: forces `tcdm.req_ready` low.
- `tcdm`, `hci_outstanding_intf.target`, HCI sizes: request/response channel.
- `mem_req_o`, out, 1: SRAM access strobe.
- `mem_we_o`, out, 1: SRAM write enable.
- `mem_addr_o`, out, MEM_AW: SRAM word address.
- `mem_wdata_o`, out, DW: SRAM write data.
- `mem_be_o`, out, DW/8: SRAM byte enables.
- `mem_rdata_i`, in, DW: SRAM read data, valid the cycle after a read strobe.
- `busy_o`, out, 1: high while any request is in flight or a response is queued.

## Operation
- Accept a request when `req_valid && req_ready`.
- `req_ready = !stall_i && !clear_i && (occ + inflight < RESP_DEPTH)`, where:
  - `occ` is the FIFO count.
  - `inflight` (0/1) is the number of requests accepted last cycle that have not yet been pushed.
- `req_wen=1` means read; `req_wen=0` means write.
- Word index: `req_add[AW-1:log2(DW/8)]`.
  - Range error when any index bit at or above MEM_AW is set.
  - On a range error, `mem_req_o` stays 0, write data is discarded, read data is returned as 0, and `resp_opc=RESP_OPC_ERR`.
- On a valid access in the accept cycle:
  - `mem_req_o=1`, `mem_we_o=!req_wen`, `mem_addr_o` = low MEM_AW index bits.
  - `mem_wdata_o=req_data`, `mem_be_o=req_be`.
- One-entry issue register (`inflight`) holds `{is_read, err, id, user}`. The next cycle it pushes `{rdata or 0, opc, id, user}` into the FIFO.
  - Reads take `mem_rdata_i`.
  - Writes return data 0 with `opc=OK`.
- The response channel presents the FIFO head: `resp_valid = !empty`. It pops on `resp_valid && resp_ready`.
- Responses leave strictly in acceptance order.
- Credit accounting guarantees a push never meets a full FIFO. No request is ever dropped.
- `clear_i`:
  - empties the FIFO and discards `inflight` at the next edge.
  - ignores `mem_rdata_i` during that edge.
  - holds `req_ready` at 0 while asserted.
- `busy_o = inflight || !empty`.

## Timing
- Reset values:
  - `resp_valid=0`, `mem_req_o=0`, `busy_o=0`, FIFO empty, `inflight=0`.
  - `req_ready=1` when `stall_i=0`.
  - All data, ID and user outputs are 0.
- Latency is 2 cycles. A request accepted at edge t produces `resp_valid` from edge t+1 into cycle t+2, assuming an empty FIFO. There is no bypass path.
- Throughput is 1 request/cycle with `resp_ready=1` and `RESP_DEPTH≥2`.
- Full: with `occ + inflight == RESP_DEPTH`, `req_ready=0`. It returns to 1 combinationally in the cycle a pop occurs. Simultaneous pop and accept is legal.
- Simultaneous push and pop:
  - FIFO count unchanged.
  - On an empty FIFO, the pushed entry appears the next cycle.
- Response signals hold stable while `resp_valid && !resp_ready`.
- Request fields are sampled only in the accept cycle.
- An asynchronous reset mid-burst discards all state. The next response after reset must belong to a post-reset request.
- `mem_*` outputs are combinational from `tcdm` request signals. `mem_req_o` is gated by accept.

## Structure
- Add to `redmule_pkg`:
  - `RESP_OPC_OK=1'b0` and `RESP_OPC_ERR=1'b1`.
  - `tcdm_resp_entry_t` packed struct `{data, opc, id, user}`, sized from the HCI params.
- Sub-module `redmule_tcdm_resp_fifo`:
  - Synchronous FIFO of `tcdm_resp_entry_t`, RESP_DEPTH entries.
  - Ports: clk, async reset, clear, push, pop, `empty`, `full`, `occ`.
  - Pointers wrap modulo RESP_DEPTH. Must support a non-power-of-two depth.
- Top level: credit logic, address check, issue register, SRAM drive, response mapping.

## Test plan
- Write `0xA5…A5` at word 3 with `be=all-ones`, id=7, then read word 3 with id=8 → write response `{id=7, opc=0, data=0}` at t+2, then read response `{id=8, data=0xA5…A5}`, in order.
- Back-to-back 8 reads with `resp_ready=1` → `req_ready` stays 1, 8 responses on consecutive cycles, IDs 0..7 in order.
- `resp_ready=0`, `RESP_DEPTH=4`, continuous reads → exactly 4 accepted, then `req_ready=0`. Raise `resp_ready` → one accept per pop, no loss or duplication.
- Read with index bit MEM_AW set → `mem_req_o=0`, response `opc=1`, `data=0`. Subsequent valid read unaffected.
- Byte-enable write `be=0x0001` over `0xFF…FF` → readback shows only byte 0 changed.
- `clear_i` pulse with 3 queued responses plus 1 in flight → `resp_valid=0` next cycle, `busy_o=0`. A new read then returns normally at 2-cycle latency.
